// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
//  Shared types and constants for the UART transmitter.
//  - tx_state_e   : one-hot frame FSM encoding (5 states)
//  - DBITS_*      : data_bits_i codes (0:5 .. 3:8 data bits)
//  - MIN_BAUD_DIV : smallest usable clocks-per-bit value
//  - data_mask()  : keeps only the data bits selected by a data_bits code
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } tx_state_e;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam int MIN_BAUD_DIV = 2;

    function automatic logic [7:0] data_mask(input logic [1:0] code);
        return 8'hFF >> (2'd3 - code);
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// ---------------------------------------------------------------------------
// uart_tx_engine_if
//  Register-block side of the UART transmitter: data-write strobe plus the
//  status/event flags read back by the register block.
//  master : register block (drives wr_en_i / wr_data_i)
//  slave  : uart_tx_engine
//  Signals:
//   wr_en_i    data-write strobe, one word per cycle high
//   wr_data_i  word to enqueue
//   tx_full_o  FIFO full          tx_empty_o  FIFO empty
//   tx_busy_o  frame in progress  tx_ovf_o    dropped-write pulse
//   tx_done_o  end-of-frame pulse
// ---------------------------------------------------------------------------
interface uart_tx_engine_if;
    logic       wr_en_i;
    logic [7:0] wr_data_i;
    logic       tx_full_o;
    logic       tx_empty_o;
    logic       tx_busy_o;
    logic       tx_ovf_o;
    logic       tx_done_o;

    modport master (
        output wr_en_i, wr_data_i,
        input  tx_full_o, tx_empty_o, tx_busy_o, tx_ovf_o, tx_done_o
    );

    modport slave (
        input  wr_en_i, wr_data_i,
        output tx_full_o, tx_empty_o, tx_busy_o, tx_ovf_o, tx_done_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//  First-word-fall-through FIFO, depth 2**W words of B bits.
//  Ports:
//   clk_i, rst_i     clock, async active-high reset
//   push_i, din_i    write request / data (ignored while full)
//   pop_i            consume head word (ignored while empty)
//   dout_o           head word, valid whenever !empty_o
//   full_o, empty_o  status from registered pointers
//   ovf_o            one-cycle pulse after a write dropped on full
//   level_o          word count (only with UART_TX_LEVEL_EN defined)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int B = 8,
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [B-1:0] din_i,
    input  logic         pop_i,
    output logic [B-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         ovf_o
`ifdef UART_TX_LEVEL_EN
    ,
    output logic [W:0]   level_o
`endif
);

    logic [B-1:0] mem [0:2**W-1];
    logic [W:0]   wptr_q, rptr_q;
    logic         wr_ok, rd_ok;

    // Extra pointer MSB tells a full wrap apart from empty.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[W] != rptr_q[W]) && (wptr_q[W-1:0] == rptr_q[W-1:0]);
    assign dout_o  = mem[rptr_q[W-1:0]];

    // Full is judged on the start-of-cycle value, so a simultaneous pop
    // does not rescue a write into a full FIFO.
    assign wr_ok = push_i && !full_o;
    assign rd_ok = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + (W+1)'(1);
            if (rd_ok) rptr_q <= rptr_q + (W+1)'(1);
            ovf_o <= push_i && full_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wptr_q[W-1:0]] <= din_i;
    end

`ifdef UART_TX_LEVEL_EN
    assign level_o = wptr_q - rptr_q;
`endif

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
//  UART transmitter: TX FIFO, baud counter and frame shifter.
//  Frame: start(0), 5-8 data bits LSB first, optional parity, 1 or 2 stops.
//  Ports:
//   clk_i, rst_i   clock, async active-high reset
//   tx_en_i        1 = frames may start; 0 = hold after current frame
//   bus            register-block interface (write strobe + status flags)
//   baud_div_i     clocks per bit, values below 2 behave as 2
//   data_bits_i    0:5 1:6 2:7 3:8 data bits
//   parity_en_i    append parity bit
//   parity_odd_i   odd (1) / even (0) parity
//   stop2_i        two stop bits
//   tx_o           serial line, idle high
//  Optional (macro UART_TX_LEVEL_EN):
//   tx_level_o     FIFO word count
//   tx_thresh_i    level threshold
//   tx_irq_o       registered (tx_level_o <= tx_thresh_i)
// ---------------------------------------------------------------------------
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int FIFO_AW = 5,
    parameter int BAUD_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tx_en_i,
    uart_tx_engine_if.slave   bus,
    input  logic [BAUD_W-1:0] baud_div_i,
    input  logic [1:0]        data_bits_i,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    input  logic              stop2_i,
    output logic              tx_o
`ifdef UART_TX_LEVEL_EN
    ,
    output logic [FIFO_AW:0]  tx_level_o,
    input  logic [FIFO_AW:0]  tx_thresh_i,
    output logic              tx_irq_o
`endif
);

    tx_state_e         state_q, state_d;
    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty, fifo_ovf;
    logic              pop, done;

    logic [7:0]        shreg_q;
    logic [2:0]        bit_cnt_q;      // data bits remaining minus one
    logic [BAUD_W-1:0] baud_cnt_q;
    logic [BAUD_W-1:0] div_q, div_eff;
    logic              par_en_q, par_q;
    logic              stop_more_q;    // a second stop bit is still owed
    logic              bit_end;

    uart_tx_fifo #(.B(8), .W(FIFO_AW)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus.wr_en_i),
        .din_i   (bus.wr_data_i),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .ovf_o   (fifo_ovf)
`ifdef UART_TX_LEVEL_EN
        ,
        .level_o (tx_level_o)
`endif
    );

    assign div_eff = (baud_div_i < BAUD_W'(MIN_BAUD_DIV)) ? BAUD_W'(MIN_BAUD_DIV) : baud_div_i;
    assign bit_end = (baud_cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_en_i && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end && bit_cnt_q == 3'd0)
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP: begin
                if (bit_end && !stop_more_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame config is captured at pop and held until the frame ends, so
    // register-block writes mid-frame only affect the next frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            baud_cnt_q  <= '0;
            div_q       <= '0;
            par_en_q    <= 1'b0;
            par_q       <= 1'b0;
            stop_more_q <= 1'b0;
        end else if (pop) begin
            shreg_q     <= fifo_dout;
            bit_cnt_q   <= {1'b0, data_bits_i} + 3'd4;
            par_en_q    <= parity_en_i;
            par_q       <= (^(fifo_dout & data_mask(data_bits_i))) ^ parity_odd_i;
            stop_more_q <= stop2_i;
            div_q       <= div_eff;
            baud_cnt_q  <= div_eff - BAUD_W'(1);
        end else if (state_q != ST_IDLE) begin
            if (bit_end) begin
                baud_cnt_q <= (state_d == ST_IDLE) ? '0 : div_q - BAUD_W'(1);
                if (state_q == ST_DATA) begin
                    shreg_q   <= shreg_q >> 1;
                    bit_cnt_q <= bit_cnt_q - 3'd1;
                end
                if (state_q == ST_STOP) stop_more_q <= 1'b0;
            end else begin
                baud_cnt_q <= baud_cnt_q - BAUD_W'(1);
            end
        end
    end

    // Line decoded straight from state so a reset returns it high at once.
    always_comb begin
        tx_o = 1'b1;
        unique case (state_q)
            ST_START:  tx_o = 1'b0;
            ST_DATA:   tx_o = shreg_q[0];
            ST_PARITY: tx_o = par_q;
            default:   tx_o = 1'b1;
        endcase
    end

    assign bus.tx_full_o  = fifo_full;
    assign bus.tx_empty_o = fifo_empty;
    assign bus.tx_busy_o  = (state_q != ST_IDLE);
    assign bus.tx_ovf_o   = fifo_ovf;
    assign bus.tx_done_o  = done;

`ifdef UART_TX_LEVEL_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tx_irq_o <= 1'b0;
        else       tx_irq_o <= (tx_level_o <= tx_thresh_i);
    end
`endif

endmodule
